sequence_timing_decoder: RTL and testbench
==========================================

Name: sequence_timing_decoder

Overview:
- Sequence counter (SC), run/halt control flip-flop (S) and timing decoder for the basic-computer control unit.
- Holds the current micro-step count and drives the one-hot timing signals T0..T(2**WIDTH-1) that gate every control-unit microoperation.
- Acts as the decoding counterpart of the one-hot encoder: it turns a binary step count into one-hot timing lines.

Parameters:
- WIDTH, 4, counter width in bits; the timing bus is 2**WIDTH bits wide.
- RESET_RUN, 0, value S takes on reset (1 = running immediately after reset).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- inr  input  1  increment SC (honoured only while running).
- clr  input  1  clear SC to 0 (honoured regardless of run state).
- start  input  1  set S (begin running).
- halt  input  1  clear S (HLT instruction).
- running  output  1  current value of S.
- sc  output  WIDTH  current step count.
- t  output  2**WIDTH  one-hot timing signals; t[i] asserted iff sc == i.
- overflow  output  1  sticky overflow flag; present only with SEQ_OVERFLOW_TRAP_EN.

Behaviour:
- Reset (rst_n low, asynchronous, effective without clk): sc=0, t=1 (T0 only), running=RESET_RUN, overflow=0. All state is held while rst_n is low. The first edge after deassertion behaves normally.
- S flip-flop, on each rising edge: halt=1 clears S; otherwise start=1 sets S; otherwise S holds. halt beats start when both are asserted.
- SC update on each rising edge, in priority order:
  1. clr=1: sc becomes 0, whether running or not.
  2. inr=1 and running=1: sc becomes sc+1, modulo 2**WIDTH (T15 wraps to T0 when WIDTH=4).
  3. Otherwise sc holds. inr is ignored while halted.
- "running" above means the S value before the edge. The edge that applies halt still honours inr; the edge that applies start does not.
- t is always exactly the one-hot decode of sc: popcount(t)==1 every cycle. t may be held as a separate register, but it must never disagree with sc. There is no extra latency: t and sc change on the same edge.
- Simultaneous clr and inr: clr wins, so sc=0.
- Halted with clr=1: sc still clears, and t shows T0.
- Both outputs are glitch-free registered values.

Optional Feature:
- Macro: SEQ_OVERFLOW_TRAP_EN.
- Defined:
  - An effective increment at sc = 2**WIDTH-1 does not wrap. sc stays at max, overflow sets, and S clears on that same edge.
  - overflow is sticky. It clears only on reset or on clr=1 together with start=1.
  - The overflow port exists.
- Undefined:
  - SC wraps modulo 2**WIDTH.
  - The overflow port is absent from the module.

Test Plan:
- Reset with RESET_RUN=0, then inr=1 for 3 cycles -> sc=0, t=16'h0001, running=0 throughout.
- start pulse, then inr=1 for 5 cycles -> running=1; sc=5, t=16'h0020.
- Running at sc=7, assert clr and inr on the same edge -> sc=0, t=16'h0001.
- Running at sc=3, assert halt and start with inr=1 -> running=0, sc=4; next edge with inr=1 leaves sc=4.
- Running from sc=14, inr for 2 cycles -> without macro: sc=15 then 0, t=16'h8000 then 16'h0001. With SEQ_OVERFLOW_TRAP_EN: sc=15, overflow=1, running=0.
- Assert rst_n low mid-count at sc=9 between clock edges -> sc=0, t=16'h0001 and running=RESET_RUN immediately, with no clk edge needed.

Source files
------------

// File: rtl/sequence_timing_decoder_if.sv
// Control-unit timing bus between the control logic and the sequence counter / timing decoder.
// The overflow signal exists only when SEQ_OVERFLOW_TRAP_EN is defined.
interface sequence_timing_decoder_if #(
    parameter int WIDTH = 4
);
    logic                  inr;
    logic                  clr;
    logic                  start;
    logic                  halt;
    logic                  running;
    logic [WIDTH-1:0]      sc;
    logic [2**WIDTH-1:0]   t;
`ifdef SEQ_OVERFLOW_TRAP_EN
    logic                  overflow;

    modport master (
        output inr, clr, start, halt,
        input  running, sc, t, overflow
    );
    modport slave (
        input  inr, clr, start, halt,
        output running, sc, t, overflow
    );
`else
    modport master (
        output inr, clr, start, halt,
        input  running, sc, t
    );
    modport slave (
        input  inr, clr, start, halt,
        output running, sc, t
    );
`endif
endinterface

// File: rtl/sequence_timing_decoder.sv
// Sequence counter, run/halt flip-flop and one-hot timing decoder for the basic-computer control unit.
// Optional macro SEQ_OVERFLOW_TRAP_EN: saturate at the last step, raise sticky overflow and halt.
module sequence_timing_decoder #(
    parameter int WIDTH     = 4,
    parameter bit RESET_RUN = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sequence_timing_decoder_if.slave bus
);
    localparam int N = 2**WIDTH;

    // The run/halt flip-flop is the only FSM; its state is visible on bus.running.
    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    localparam run_state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

    run_state_t       state_q, state_d;
    logic [WIDTH-1:0] sc_q, sc_d;
    logic [N-1:0]     t_q, t_d;
    logic             ovf_q, ovf_d;
    logic             inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            sc_q    <= '0;
            t_q     <= {{(N-1){1'b0}}, 1'b1};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            t_q     <= t_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        ovf_d   = ovf_q;
        t_d     = '0;
        // Increments are gated by the run state before the edge, so a halting edge still counts.
        inc     = bus.inr && (state_q == ST_RUN);

        if (bus.halt) begin
            state_d = ST_HALT;
        end else if (bus.start) begin
            state_d = ST_RUN;
        end

        if (bus.clr) begin
            sc_d = '0;
`ifdef SEQ_OVERFLOW_TRAP_EN
            if (bus.start) begin
                ovf_d = 1'b0;
            end
`endif
        end else if (inc) begin
`ifdef SEQ_OVERFLOW_TRAP_EN
            if (sc_q == {WIDTH{1'b1}}) begin
                ovf_d   = 1'b1;
                state_d = ST_HALT;
            end else begin
                sc_d = sc_q + 1'b1;
            end
`else
            sc_d = sc_q + 1'b1;
`endif
        end

        // Decode the next count so t and sc always move on the same edge.
        t_d[sc_d] = 1'b1;
    end

    assign bus.running = (state_q == ST_RUN);
    assign bus.sc      = sc_q;
    assign bus.t       = t_q;
`ifdef SEQ_OVERFLOW_TRAP_EN
    assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_sequence_timing_decoder.sv
// Bench for sequence_timing_decoder: directed test-plan cases plus random stimulus against a step-count model.
module tb_sequence_timing_decoder;
    localparam int WIDTH = 4;
    localparam int N     = 2**WIDTH;
    localparam bit RESET_RUN = 1'b0;

    logic clk;
    logic rst_n;

    sequence_timing_decoder_if #(.WIDTH(WIDTH)) bus ();

    sequence_timing_decoder #(
        .WIDTH(WIDTH),
        .RESET_RUN(RESET_RUN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model: step count as an integer, run flag, sticky overflow
    int n_checks = 0;
    int n_fail   = 0;
    int m_sc;
    bit m_run;
    bit m_ovf;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sc  = 0;
        m_run = RESET_RUN;
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input bit i, input bit c, input bit s, input bit h);
        bit was_running;
        was_running = m_run;
        if (h)      m_run = 1'b0;
        else if (s) m_run = 1'b1;
        if (c) begin
            m_sc = 0;
            if (s) m_ovf = 1'b0;
        end else if (i && was_running) begin
            if (m_sc == N-1) begin
`ifdef SEQ_OVERFLOW_TRAP_EN
                m_ovf = 1'b1;
                m_run = 1'b0;
`else
                m_sc = 0;
`endif
            end else begin
                m_sc = m_sc + 1;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_t(input int sc);
        logic [N-1:0] one;
        one = 1;
        return one << sc;
    endfunction

    // driver: inputs change after the falling edge, model follows the rising edge
    task automatic step(input bit i, input bit c, input bit s, input bit h);
        bus.inr   = i;
        bus.clr   = c;
        bus.start = s;
        bus.halt  = h;
        @(posedge clk);
        model_edge(i, c, s, h);
        @(negedge clk);
    endtask

    // scoreboard compare on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("sc", 64'(bus.sc), 64'(m_sc));
            check("t", 64'(bus.t), 64'(exp_t(m_sc)));
            check("running", 64'(bus.running), 64'(m_run));
            check("t_onehot", 64'($countones(bus.t)), 64'd1);
`ifdef SEQ_OVERFLOW_TRAP_EN
            check("overflow", 64'(bus.overflow), 64'(m_ovf));
`endif
        end
    end

    initial begin
        rst_n     = 1'b0;
        bus.inr   = 1'b0;
        bus.clr   = 1'b0;
        bus.start = 1'b0;
        bus.halt  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_sc", 64'(bus.sc), 64'd0);
        check("reset_t", 64'(bus.t), 64'h0001);
        check("reset_running", 64'(bus.running), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // halted: inr ignored
        repeat (3) step(1, 0, 0, 0);
        check("halted_inr_sc", 64'(bus.sc), 64'd0);
        check("halted_inr_t", 64'(bus.t), 64'h0001);
        check("halted_inr_running", 64'(bus.running), 64'd0);

        // start edge does not count, then five increments
        step(1, 0, 1, 0);
        check("start_edge_sc", 64'(bus.sc), 64'd0);
        repeat (5) step(1, 0, 0, 0);
        check("count5_running", 64'(bus.running), 64'd1);
        check("count5_sc", 64'(bus.sc), 64'd5);
        check("count5_t", 64'(bus.t), 64'h0020);

        // clr beats inr at sc=7
        repeat (2) step(1, 0, 0, 0);
        check("at7_sc", 64'(bus.sc), 64'd7);
        step(1, 1, 0, 0);
        check("clr_inr_sc", 64'(bus.sc), 64'd0);
        check("clr_inr_t", 64'(bus.t), 64'h0001);

        // halt beats start; halting edge still counts
        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 1, 1);
        check("halt_start_running", 64'(bus.running), 64'd0);
        check("halt_start_sc", 64'(bus.sc), 64'd4);
        step(1, 0, 0, 0);
        check("halted_hold_sc", 64'(bus.sc), 64'd4);

        // wrap / trap at the last step
        step(0, 1, 1, 0);
        repeat (14) step(1, 0, 0, 0);
        check("at14_sc", 64'(bus.sc), 64'd14);
        step(1, 0, 0, 0);
        check("at15_sc", 64'(bus.sc), 64'd15);
        check("at15_t", 64'(bus.t), 64'h8000);
        step(1, 0, 0, 0);
`ifdef SEQ_OVERFLOW_TRAP_EN
        check("trap_sc", 64'(bus.sc), 64'd15);
        check("trap_overflow", 64'(bus.overflow), 64'd1);
        check("trap_running", 64'(bus.running), 64'd0);
        step(0, 1, 0, 0);
        check("halted_clr_t", 64'(bus.t), 64'h0001);
        check("sticky_overflow", 64'(bus.overflow), 64'd1);
        step(0, 1, 1, 0);
        check("ovf_clear", 64'(bus.overflow), 64'd0);
`else
        check("wrap_sc", 64'(bus.sc), 64'd0);
        check("wrap_t", 64'(bus.t), 64'h0001);
        step(0, 0, 1, 1);
        step(0, 1, 0, 0);
        check("halted_clr_t", 64'(bus.t), 64'h0001);
`endif

        // asynchronous reset mid-count at sc=9, between edges
        step(0, 1, 1, 0);
        repeat (9) step(1, 0, 0, 0);
        check("at9_sc", 64'(bus.sc), 64'd9);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_sc", 64'(bus.sc), 64'd0);
        check("async_t", 64'(bus.t), 64'h0001);
        check("async_running", 64'(bus.running), 64'(RESET_RUN));
        bus.inr   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // random stimulus against the model
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
